// File: rtl/nonce_search_ctrl.sv
// nonce_search_ctrl: walks nonces over a latched 12-byte entry and stops on a hash hit, nonce exhaustion or hash timeout
module nonce_search_ctrl #(
  parameter logic [31:0] NONCE_START = 32'h0000_0000,
  parameter logic [31:0] NONCE_LAST  = 32'hFFFF_FFFF,
  parameter logic [15:0] TIMEOUT     = 16'd1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [95:0]  entry_12,
  input  logic [7:0]   target,
  output logic [127:0] block_out,
  output logic         block_vld,
  input  logic         hash_done,
  input  logic [23:0]  H_out,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic         timeout,
  output logic [31:0]  nonce_out,
  output logic [23:0]  hash_out
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, FOUND, EXHAUST, TOUT} state_t;
  state_t state;
  logic [95:0] entry_l;
  logic [7:0]  target_l;
  logic [31:0] nonce;
  logic [15:0] cnt;
  logic        hit;
  assign hit = (H_out[23:16] < target_l) && (H_out[15:8] < target_l);
  // Search FSM; block_out/block_vld are loaded on entry to LOAD so the hash core sees the block during LOAD,
  // and the wait counter already runs in LOAD so the timeout lands TIMEOUT cycles after block_vld.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      entry_l   <= '0;
      target_l  <= '0;
      nonce     <= NONCE_START;
      cnt       <= '0;
      block_out <= '0;
      block_vld <= 1'b0;
      busy      <= 1'b0;
      found     <= 1'b0;
      exhausted <= 1'b0;
      timeout   <= 1'b0;
      nonce_out <= '0;
      hash_out  <= '0;
    end else begin
      case (state)
        IDLE, FOUND, EXHAUST, TOUT: if (start) begin
          entry_l   <= entry_12;
          target_l  <= target;
          nonce     <= NONCE_START;
          nonce_out <= NONCE_START;
          found     <= 1'b0;
          exhausted <= 1'b0;
          timeout   <= 1'b0;
          hash_out  <= '0;
          block_out <= {entry_12, NONCE_START};
          block_vld <= 1'b1;
          busy      <= 1'b1;
          cnt       <= '0;
          state     <= LOAD;
        end
        LOAD: begin
          block_vld <= 1'b0;
          cnt       <= cnt + 16'd1;
          state     <= WAIT;
        end
        WAIT: if (hash_done) begin
          if (hit) begin
            found     <= 1'b1;
            hash_out  <= H_out;
            nonce_out <= nonce;
            busy      <= 1'b0;
            state     <= FOUND;
          end else if (nonce == NONCE_LAST) begin
            exhausted <= 1'b1;
            busy      <= 1'b0;
            state     <= EXHAUST;
          end else begin
            nonce     <= nonce + 32'd1;
            nonce_out <= nonce + 32'd1;
            block_out <= {entry_l, nonce + 32'd1};
            block_vld <= 1'b1;
            cnt       <= '0;
            state     <= LOAD;
          end
        end else if (cnt >= TIMEOUT - 16'd1) begin
          timeout <= 1'b1;
          busy    <= 1'b0;
          state   <= TOUT;
        end else cnt <= cnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
